// File: rtl/bid_bank_pkg.sv
// Shared constants and the saturating balance helper used by the bidder
// credit banks and the four-way bidding arbiter.
package bid_bank_pkg;

    // Widths shared between the arbiter and every bank instance.
    localparam int BAL_W = 10;
    localparam int BID_W = 4;

    // Default account settings.
    localparam int DEF_INIT_BALANCE  = 100;
    localparam int DEF_MAX_BALANCE   = 1023;
    localparam int DEF_REFILL_PERIOD = 16;
    localparam int DEF_REFILL_AMOUNT = 8;

    // Net credit/debit at BAL_W+2 signed bits so nothing wraps before the
    // clamp. The arbiter may grant a bidder whose balance is below its bid,
    // so a negative result floors at zero; the top end saturates at ceiling.
    function automatic logic [BAL_W-1:0] sat_update(
        input logic [BAL_W-1:0] bal,
        input logic [BAL_W-1:0] credit,
        input logic [BID_W-1:0] debit,
        input logic [BAL_W-1:0] ceiling
    );
        logic signed [BAL_W+1:0] nxt;
        nxt = $signed({2'b00, bal}) + $signed({2'b00, credit})
            - $signed({{(BAL_W + 2 - BID_W){1'b0}}, debit});
        if (nxt < 0) begin
            return '0;
        end else if (nxt > $signed({2'b00, ceiling})) begin
            return ceiling;
        end else begin
            return nxt[BAL_W-1:0];
        end
    endfunction

endpackage

// File: rtl/bid_bank_refill_timer.sv
// Free-running refill timer: counts 0..PERIOD-1 and pulses tick on the last
// count. Independent of any bid/grant activity so other credit blocks can
// reuse it as-is.
module bid_bank_refill_timer #(
    parameter int PERIOD = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // A period of 1 still needs a 1-bit counter; it simply stays at 0.
    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    // Advance the phase every cycle, wrapping after the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bid_bank.sv
// Per-bidder credit account. The balance is debited by the bid whenever this
// bidder is granted and credited by a fixed amount on every refill tick. Both
// effects are netted in a single step and clamped to [0, MAX_BALANCE].
// grant only reaches the balance through the register, so there is no
// combinational path back into the arbiter.
module bid_bank
    import bid_bank_pkg::*;
#(
    parameter int BAL_W         = bid_bank_pkg::BAL_W,
    parameter int BID_W         = bid_bank_pkg::BID_W,
    parameter int INIT_BALANCE  = DEF_INIT_BALANCE,
    parameter int MAX_BALANCE   = DEF_MAX_BALANCE,
    parameter int REFILL_PERIOD = DEF_REFILL_PERIOD,
    parameter int REFILL_AMOUNT = DEF_REFILL_AMOUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BID_W-1:0] bid,
    input  logic             grant,
    output logic [BAL_W-1:0] balance
);

    localparam logic [BAL_W-1:0] INIT_V   = BAL_W'(INIT_BALANCE);
    localparam logic [BAL_W-1:0] MAX_V    = BAL_W'(MAX_BALANCE);
    localparam logic [BAL_W-1:0] REFILL_V = BAL_W'(REFILL_AMOUNT);

    logic             refill_tick;
    logic [BID_W-1:0] debit;
    logic [BAL_W-1:0] credit;

    bid_bank_refill_timer #(
        .PERIOD (REFILL_PERIOD)
    ) u_refill_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (refill_tick)
    );

    // Select this cycle's debit and credit; a zero bid debits nothing.
    always_comb begin
        debit  = grant ? bid : '0;
        credit = refill_tick ? REFILL_V : '0;
    end

    // Apply the netted change once per edge; reset discards any pending update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            balance <= INIT_V;
        end else begin
            balance <= sat_update(balance, credit, debit, MAX_V);
        end
    end

endmodule

// File: tb/tb_bid_bank.sv
// Self-checking bench for bid_bank: directed scenarios plus random traffic,
// compared against a plain-arithmetic account model.
module tb_bid_bank;

    localparam int PERIOD = 16;
    localparam int AMT    = 8;
    localparam int INIT   = 100;
    localparam int MAXB   = 1023;

    logic       clk = 1'b0;
    logic       rst;
    logic       grant;
    logic [3:0] bid;
    logic [9:0] balance;

    int checks   = 0;
    int failures = 0;

    // Reference account: balance and number of clock edges since reset.
    int m_bal   = INIT;
    int m_edges = 0;

    logic [9:0] exp_q[$];

    bid_bank dut (
        .clk     (clk),
        .rst     (rst),
        .bid     (bid),
        .grant   (grant),
        .balance (balance)
    );

    // Clock / watchdog.
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // A refill lands on every PERIOD-th edge counted from reset release.
    function automatic bit next_is_tick();
        return ((m_edges + 1) % PERIOD) == 0;
    endfunction

    // Drive one cycle (caller is between edges), advance the model and check.
    task automatic step(input logic g, input logic [3:0] b);
        int nb;
        grant = g;
        bid   = b;
        nb = m_bal + (next_is_tick() ? AMT : 0) - (g ? int'(b) : 0);
        if (nb < 0) nb = 0;
        if (nb > MAXB) nb = MAXB;
        m_bal = nb;
        m_edges++;
        exp_q.push_back(10'(nb));
        @(posedge clk);
        #1;
        check_eq("step", balance, exp_q.pop_front());
    endtask

    // Assert rst between edges and confirm it takes effect without a clock.
    task automatic async_reset();
        grant = 1'b0;
        bid   = '0;
        #2 rst = 1'b1;
        #1 check_eq("async_rst", balance, 10'(INIT));
        m_bal   = INIT;
        m_edges = 0;
        @(posedge clk);
        #1 check_eq("rst_hold", balance, 10'(INIT));
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Steer the balance to target. want: 0 any phase, 1 next edge is a
    // refill, 2 next edge is not a refill.
    task automatic steer(input int target, input int want, input string tag);
        int n = 0;
        int d;
        bit tk;
        while (1) begin
            tk = next_is_tick();
            if (m_bal == target && (want == 0 || (want == 1 && tk) || (want == 2 && !tk)))
                break;
            if (n >= 4000) begin
                checks++;
                failures++;
                $display("FAIL %s steer bound got=%0d exp=%0d", tag, m_bal, target);
                break;
            end
            d = m_bal + (tk ? AMT : 0) - target;
            if (d < 0) d = 0;
            if (d > 15) d = 15;
            if (d == 0) step(1'($urandom_range(0, 1)), 4'd0);
            else        step(1'b1, 4'(d));
            n++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        grant = 1'b0;
        bid   = '0;
        repeat (2) @(posedge clk);
        #1 check_eq("reset_val", balance, 10'(INIT));
        @(negedge clk);
        rst = 1'b0;

        // Debit: three grants of 9, no refill in the way.
        step(1'b1, 4'd9); check_eq("debit_1", balance, 10'd91);
        step(1'b1, 4'd9); check_eq("debit_2", balance, 10'd82);
        step(1'b1, 4'd9); check_eq("debit_3", balance, 10'd73);

        // Async reset from balance 37.
        steer(37, 0, "to_37");
        check_eq("at_37", balance, 10'd37);
        async_reset();

        // Refill cadence from a fresh reset.
        for (int i = 1; i <= 32; i++) begin
            step(1'b0, 4'd0);
            if (i == 15) check_eq("refill_pre", balance, 10'd100);
            if (i == 16) check_eq("refill_1", balance, 10'd108);
            if (i == 32) check_eq("refill_2", balance, 10'd116);
        end

        // Underflow clamp.
        steer(5, 2, "to_5");
        step(1'b1, 4'd12); check_eq("underflow", balance, 10'd0);
        steer(0, 2, "hold_0");
        step(1'b1, 4'd12); check_eq("underflow_rep", balance, 10'd0);

        // Overflow clamp.
        steer(1020, 1, "to_1020");
        step(1'b0, 4'd0); check_eq("overflow", balance, 10'd1023);
        for (int i = 0; i < 16; i++) step(1'b0, 4'd0);
        check_eq("overflow_rep", balance, 10'd1023);

        // Simultaneous grant and refill.
        steer(50, 1, "to_50");
        step(1'b1, 4'd15); check_eq("net_update", balance, 10'd43);
        step(1'b1, 4'd0);  check_eq("zero_bid", balance, 10'd43);

        // Random traffic with occasional mid-operation resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            else step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
